bram_save_ctrl: RTL and testbench
=================================

Name: bram_save_ctrl

Overview:
- Parametrised backup-RAM save/load/format sequencer between the core's dual-port backup RAM (port B) and the hps_io SD sector interface.
- Generalises the fixed 16-sector, 4-slot save logic to configurable sector count, slot count and format image.
- Adds an ACK timeout with error reporting, dirty tracking and full-image zero-fill on format.
- Sits in the emu top level next to hps_io; its busy_load output is ORed into the core reset.

Parameters:
SECTORS, 16, 512-byte sectors per save slot; power of 2, 1..256.
SLOT_BITS, 2, number of slot-select bits; 2^SLOT_BITS slots.
HDR0..HDR3, 16'h5548, 16'h4D42, 16'h8800, 16'h8010, format header words written at word addresses 0..3.
TO_W, 24, width of the ACK timeout counter; timeout fires at 2^TO_W-1 cycles.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  save image mounted and writable; load/save ignored when 0
load_req  in  1  level; rising edge starts a load
save_req  in  1  level; rising edge starts a save
format_req  in  1  level; rising edge starts a format
slot  in  SLOT_BITS  slot select, sampled at start
core_wr  in  1  core write strobe to backup RAM; sets dirty
sd_lba  out  32  sector address
sd_rd  out  1  sector read request
sd_wr  out  1  sector write request
sd_ack  in  1  hps_io sector acknowledge
sd_buff_addr  in  8  word index within sector
sd_buff_dout  in  16  data from HPS
sd_buff_wr  in  1  HPS data strobe
ram_addr  out  log2(SECTORS)+8  backup RAM port B word address
ram_din  out  16  backup RAM port B write data
ram_we  out  1  backup RAM port B write enable
busy  out  1  any operation in progress
busy_load  out  1  load or format in progress (core held in reset)
dirty  out  1  RAM modified since last load/save/format
err  out  1  sticky ACK timeout flag

Behaviour:
- Reset values: sd_lba=0, sd_rd=0, sd_wr=0, ram_we=0, busy=0, busy_load=0, dirty=0, err=0. State=IDLE. Edge-detect registers are loaded with the current request levels, so a request held high through reset does not start an operation.
- Requests: rising-edge detected on registered copies. Edges that arrive while busy are dropped, not queued.
- Request priority in IDLE, same cycle: format > load > save. load/save also require enable=1; format does not.
- IDLE -> REQ on load/save:
  - Latch op and slot; idx=0.
  - sd_lba={zeros, slot, idx}, where idx is log2(SECTORS) bits.
  - Assert sd_rd (load) or sd_wr (save) the next cycle. Clear the timeout counter.
- REQ:
  - On sd_ack rise, deassert sd_rd/sd_wr and go to XFER.
  - If the counter saturates first: deassert requests, set err, go to IDLE. Partial loaded data stays in RAM.
- XFER: on sd_ack fall:
  - If idx==SECTORS-1, go to IDLE, clear dirty and err.
  - Otherwise idx++, update sd_lba, return to REQ (request re-asserted one cycle later).
- RAM port during load/save:
  - ram_addr={idx, sd_buff_addr}.
  - ram_din=sd_buff_dout.
  - ram_we=sd_buff_wr & sd_ack & (op==load), combinational.
- Save data returns to HPS via RAM port B q. Read latency is one cycle and is absorbed by hps_io.
- FORMAT:
  - Counter w runs from 0 to SECTORS*256-1, one word per cycle.
  - ram_we=1, ram_addr=w.
  - ram_din=HDRw for w<4, else 0.
  - Done after the last word: dirty=1, return to IDLE. Duration is exactly SECTORS*256 cycles.
- busy=1 in every state except IDLE. busy_load=1 in REQ/XFER with op==load, and in FORMAT.
- dirty: set by core_wr in any state, including during a save; a set from core_wr wins over the clear at save completion in the same cycle.
- sd_lba upper bits are always 0. Slot changes mid-operation are ignored.
- Async reset mid-operation: return to IDLE immediately, sd_rd/sd_wr drop, partial RAM contents are kept.

Test Plan:
- Format with SECTORS=16: pulse format_req -> ram_we high for exactly 4096 cycles; words 0..3 = 5548,4D42,8800,8010; word 4095=0; dirty=1; busy_load high throughout.
- Load, slot=2, HPS model acks each request after 10 cycles and streams 256 words -> sd_lba 0x20..0x2F in order, sd_rd cleared on every ack rise, RAM word 0x123 = pattern, busy_load falls after 16th ack fall, dirty=0.
- Save, slot=3 -> sd_wr pulses 16 times, lba 0x30..0x3F, ram_we never asserted; core_wr mid-save -> dirty=1 at end.
- load_req and save_req rise same cycle with enable=1 -> load performed; with enable=0 -> nothing, busy stays 0; save_req edge during busy dropped.
- TO_W=8, HPS never acks -> sd_rd deasserts after 255 cycles, err=1, busy=0; next successful load clears err.
- reset_n low during sector 5 of a load -> sd_rd=0, busy=0 asynchronously; after release, held-high load_req does not restart the load.

Source files
------------

// File: rtl/bram_save_ctrl_if.sv
// hps_io SD sector port as seen by the backup-RAM save sequencer.
// Handshake: the controller raises sd_rd/sd_wr with sd_lba stable and holds it until
// sd_ack rises; while sd_ack is high the HPS moves words (sd_buff_wr qualifies
// each incoming word at sd_buff_addr); the sector is complete when sd_ack falls.
interface bram_save_ctrl_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;

  modport master (
    output sd_lba, sd_rd, sd_wr,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/bram_save_ctrl.sv
// Backup-RAM save/load/format sequencer between the core's dual-port RAM (port B)
// and the hps_io SD sector interface, with ACK timeout, dirty tracking and format fill.
module bram_save_ctrl #(
  parameter int unsigned SECTORS   = 16,
  parameter int unsigned SLOT_BITS = 2,
  parameter logic [15:0] HDR0      = 16'h5548,
  parameter logic [15:0] HDR1      = 16'h4D42,
  parameter logic [15:0] HDR2      = 16'h8800,
  parameter logic [15:0] HDR3      = 16'h8010,
  parameter int unsigned TO_W      = 24,
  localparam int unsigned IW_RAW   = $clog2(SECTORS),
  localparam int unsigned IW       = (IW_RAW == 0) ? 1 : IW_RAW,
  localparam int unsigned AW       = IW_RAW + 8
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 load_req,
  input  logic                 save_req,
  input  logic                 format_req,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 core_wr,
  bram_save_ctrl_if.master     sd,
  output logic [AW-1:0]        ram_addr,
  output logic [15:0]          ram_din,
  output logic                 ram_we,
  output logic                 busy,
  output logic                 busy_load,
  output logic                 dirty,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_XFER   = 2'd2,
    S_FORMAT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic                   op_load_q, op_load_d;
  logic [SLOT_BITS-1:0]   slot_q, slot_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [AW-1:0]          w_q, w_d;
  logic [TO_W-1:0]        to_q, to_d;
  logic [31:0]            lba_q, lba_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   dirty_q, dirty_d;
  logic                   err_q, err_d;
  logic                   touched_q, touched_d;
  logic                   load_lvl_q, save_lvl_q, format_lvl_q;
  logic                   ack_q;

  logic                   load_rise, save_rise, format_rise;
  logic                   ack_rise, ack_fall;
  logic                   idx_last, to_expire;
  logic [IW-1:0]          idx_inc;
  logic [TO_W-1:0]        to_inc;
  logic [15:0]            fmt_word;

  function automatic logic [31:0] make_lba(input logic [SLOT_BITS-1:0] s,
                                           input logic [IW-1:0] i);
    logic [31:0] l;
    l = (32'(s) << IW_RAW) | 32'(i);
    return l;
  endfunction

  assign load_rise   = load_req & ~load_lvl_q;
  assign save_rise   = save_req & ~save_lvl_q;
  assign format_rise = format_req & ~format_lvl_q;
  assign ack_rise    = sd.sd_ack & ~ack_q;
  assign ack_fall    = ~sd.sd_ack & ack_q;

  assign idx_inc   = idx_q + IW'(1);
  assign idx_last  = (32'(idx_q) == 32'(SECTORS - 1));
  assign to_inc    = to_q + TO_W'(1);
  assign to_expire = (to_inc == {TO_W{1'b1}});

  always_comb begin
    state_d   = state_q;
    op_load_d = op_load_q;
    slot_d    = slot_q;
    idx_d     = idx_q;
    w_d       = w_q;
    to_d      = to_q;
    lba_d     = lba_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    dirty_d   = dirty_q;
    err_d     = err_q;
    touched_d = touched_q | core_wr;

    unique case (state_q)
      S_IDLE: begin
        if (format_rise) begin
          w_d     = '0;
          state_d = S_FORMAT;
        end else if (enable && (load_rise || save_rise)) begin
          op_load_d = load_rise;
          slot_d    = slot;
          idx_d     = '0;
          lba_d     = make_lba(slot, '0);
          to_d      = '0;
          rd_d      = load_rise;
          wr_d      = ~load_rise;
          touched_d = core_wr;
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (to_expire) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_inc;
        end
      end

      S_XFER: begin
        if (ack_fall) begin
          if (idx_last) begin
            // A save only leaves the RAM clean if the core did not write during it.
            dirty_d = op_load_q ? 1'b0 : touched_q;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_inc;
            lba_d   = make_lba(slot_q, idx_inc);
            to_d    = '0;
            rd_d    = op_load_q;
            wr_d    = ~op_load_q;
            state_d = S_REQ;
          end
        end
      end

      S_FORMAT: begin
        if (w_q == {AW{1'b1}}) begin
          dirty_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          w_d = w_q + AW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (core_wr) dirty_d = 1'b1;
  end

  always_comb begin
    fmt_word = 16'h0000;
    if (w_q == AW'(0))      fmt_word = HDR0;
    else if (w_q == AW'(1)) fmt_word = HDR1;
    else if (w_q == AW'(2)) fmt_word = HDR2;
    else if (w_q == AW'(3)) fmt_word = HDR3;
  end

  always_comb begin
    ram_addr = AW'({idx_q, sd.sd_buff_addr});
    ram_din  = sd.sd_buff_dout;
    ram_we   = 1'b0;
    if (state_q == S_FORMAT) begin
      ram_addr = w_q;
      ram_din  = fmt_word;
      ram_we   = 1'b1;
    end else if (state_q == S_REQ || state_q == S_XFER) begin
      ram_we = sd.sd_buff_wr & sd.sd_ack & op_load_q;
    end
  end

  // Request level registers come out of reset high so a request held through
  // reset is not seen as a fresh edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_load_q    <= 1'b0;
      slot_q       <= '0;
      idx_q        <= '0;
      w_q          <= '0;
      to_q         <= '0;
      lba_q        <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      dirty_q      <= 1'b0;
      err_q        <= 1'b0;
      touched_q    <= 1'b0;
      load_lvl_q   <= 1'b1;
      save_lvl_q   <= 1'b1;
      format_lvl_q <= 1'b1;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_load_q    <= op_load_d;
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      w_q          <= w_d;
      to_q         <= to_d;
      lba_q        <= lba_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      dirty_q      <= dirty_d;
      err_q        <= err_d;
      touched_q    <= touched_d;
      load_lvl_q   <= load_req;
      save_lvl_q   <= save_req;
      format_lvl_q <= format_req;
      ack_q        <= sd.sd_ack;
    end
  end

  assign sd.sd_lba = lba_q;
  assign sd.sd_rd  = rd_q;
  assign sd.sd_wr  = wr_q;

  assign busy      = (state_q != S_IDLE);
  assign busy_load = (state_q == S_FORMAT) ||
                     (((state_q == S_REQ) || (state_q == S_XFER)) && op_load_q);
  assign dirty     = dirty_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bram_save_ctrl.sv
// Bench for bram_save_ctrl: HPS sector model, RAM port-B write monitor and
// scoreboard queues for expected LBAs and expected RAM writes.
module tb_bram_save_ctrl;
  localparam int SECTORS   = 16;
  localparam int SLOT_BITS = 2;
  localparam int TO_W      = 8;
  localparam int AW        = 12;

  logic                 clk_sys = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 load_req = 1'b0;
  logic                 save_req = 1'b0;
  logic                 format_req = 1'b0;
  logic                 core_wr = 1'b0;
  logic [SLOT_BITS-1:0] slot = '0;
  logic [AW-1:0]        ram_addr;
  logic [15:0]          ram_din;
  logic                 ram_we;
  logic                 busy, busy_load, dirty, err;
  logic [1:0]           dbg_state;

  bram_save_ctrl_if sd_if ();

  bram_save_ctrl #(
    .SECTORS  (SECTORS),
    .SLOT_BITS(SLOT_BITS),
    .TO_W     (TO_W)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .enable    (enable),
    .load_req  (load_req),
    .save_req  (save_req),
    .format_req(format_req),
    .slot      (slot),
    .core_wr   (core_wr),
    .sd        (sd_if),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .busy      (busy),
    .busy_load (busy_load),
    .dirty     (dirty),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  int          n_checks = 0;
  int          n_bad = 0;
  int          we_cnt = 0;
  logic [15:0] mem [0:4095];
  logic [31:0] exp_q[$];
  logic [31:0] lba_exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pat(input logic [31:0] lba, input int w);
    logic [15:0] ww;
    ww = 16'(w);
    return (lba[15:0] * 16'd257) ^ (ww * 16'd19) ^ 16'h5A3C;
  endfunction

  function automatic logic [15:0] fmt_word(input int w);
    case (w)
      0: return 16'h5548;
      1: return 16'h4D42;
      2: return 16'h8800;
      3: return 16'h8010;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // RAM port-B model plus write scoreboard, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (ram_we) begin
      we_cnt++;
      mem[ram_addr] = ram_din;
      if (exp_q.size() == 0) begin
        check_eq("ram_we_unexp", 32'(ram_we), 32'd0);
      end else begin
        check_eq("ram_wr", {4'd0, ram_addr, ram_din}, exp_q.pop_front());
      end
    end
  end

  // HPS sector model: waits for a request, acks after `delay` cycles, moves 256 words
  task automatic hps_serve(input bit is_load, input int nsec, input int delay, input int cw_sec);
    int n;
    logic [31:0] lba_exp;
    for (int s = 0; s < nsec; s++) begin
      n = 0;
      while (!(sd_if.sd_rd || sd_if.sd_wr) && n < 300) begin
        step();
        n++;
      end
      check_eq("req_kind", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, is_load ? 32'd2 : 32'd1);
      check_eq("busy_load_xfer", 32'(busy_load), 32'(is_load));
      check_eq("lba_q_nonempty", 32'(lba_exp_q.size() != 0), 32'd1);
      lba_exp = (lba_exp_q.size() != 0) ? lba_exp_q.pop_front() : 32'hFFFF_FFFF;
      check_eq("lba", sd_if.sd_lba, lba_exp);
      repeat (delay) step();
      sd_if.sd_ack = 1'b1;
      step();
      check_eq("req_clr", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
      for (int w = 0; w < 256; w++) begin
        sd_if.sd_buff_addr = 8'(w);
        sd_if.sd_buff_dout = pat(lba_exp, w);
        sd_if.sd_buff_wr   = is_load;
        core_wr            = (s == cw_sec) && (w == 100);
        if (is_load) exp_q.push_back({4'd0, 4'(s), 8'(w), pat(lba_exp, w)});
        step();
      end
      sd_if.sd_buff_wr = 1'b0;
      core_wr          = 1'b0;
      sd_if.sd_ack     = 1'b0;
      step();
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      step();
      n++;
    end
    check_eq(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int bl_low;
    sd_if.sd_ack       = 1'b0;
    sd_if.sd_buff_addr = 8'd0;
    sd_if.sd_buff_dout = 16'd0;
    sd_if.sd_buff_wr   = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'hFFFF;

    // reset values
    repeat (3) step();
    check_eq("rst_lba", sd_if.sd_lba, 32'd0);
    check_eq("rst_rdwr", {30'd0, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
    check_eq("rst_we", 32'(ram_we), 32'd0);
    check_eq("rst_busy", {30'd0, busy, busy_load}, 32'd0);
    check_eq("rst_dirty_err", {30'd0, dirty, err}, 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    #2 reset_n = 1'b1;
    step();
    step();

    core_wr = 1'b1;
    step();
    core_wr = 1'b0;
    check_eq("core_wr_dirty", 32'(dirty), 32'd1);

    // format
    for (int w = 0; w < 4096; w++) exp_q.push_back({4'd0, 12'(w), fmt_word(w)});
    we_cnt = 0;
    format_req = 1'b1;
    step();
    step();
    format_req = 1'b0;
    check_eq("fmt_busy", {30'd0, busy, busy_load}, 32'd3);
    n = 0;
    bl_low = 0;
    while (busy && n < 6000) begin
      if (!busy_load) bl_low++;
      step();
      n++;
    end
    check_eq("fmt_done", 32'(busy), 32'd0);
    check_eq("fmt_we_cnt", 32'(we_cnt), 32'd4096);
    check_eq("fmt_bl_low", 32'(bl_low), 32'd0);
    check_eq("fmt_w0", 32'(mem[0]), 32'h5548);
    check_eq("fmt_w1", 32'(mem[1]), 32'h4D42);
    check_eq("fmt_w2", 32'(mem[2]), 32'h8800);
    check_eq("fmt_w3", 32'(mem[3]), 32'h8010);
    check_eq("fmt_w4095", 32'(mem[4095]), 32'h0);
    check_eq("fmt_dirty", 32'(dirty), 32'd1);
    check_eq("fmt_exp_empty", 32'(exp_q.size()), 32'd0);

    // load slot 2, slot changed mid-op
    enable = 1'b1;
    slot = 2'd2;
    for (int i = 0; i < 16; i++) lba_exp_q.push_back(32'h20 + 32'(i));
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    slot = 2'd0;
    hps_serve(1'b1, 16, 10, -1);
    check_eq("load_done", {30'd0, busy, busy_load}, 32'd0);
    check_eq("load_dirty_err", {30'd0, dirty, err}, 32'd0);
    check_eq("load_word_123", 32'(mem[12'h123]), 32'(pat(32'h21, 32'h23)));
    check_eq("load_exp_empty", 32'(exp_q.size() + lba_exp_q.size()), 32'd0);

    // save slot 3: with a core write mid-save, then a clean save
    for (int k = 0; k < 2; k++) begin
      slot = 2'd3;
      for (int i = 0; i < 16; i++) lba_exp_q.push_back(32'h30 + 32'(i));
      save_req = 1'b1;
      step();
      save_req = 1'b0;
      hps_serve(1'b0, 16, 3, (k == 0) ? 7 : -1);
      wait_idle("save_done", 20);
      check_eq("save_dirty", 32'(dirty), (k == 0) ? 32'd1 : 32'd0);
      check_eq("save_err", 32'(err), 32'd0);
    end

    // load and save rise together; save edge during busy is dropped
    slot = 2'd1;
    for (int i = 0; i < 16; i++) lba_exp_q.push_back(32'h10 + 32'(i));
    load_req = 1'b1;
    save_req = 1'b1;
    step();
    load_req = 1'b0;
    save_req = 1'b0;
    fork
      begin
        repeat (40) step();
        save_req = 1'b1;
      end
    join_none
    hps_serve(1'b1, 16, 5, -1);
    repeat (10) step();
    check_eq("save_dropped", {30'd0, busy, sd_if.sd_wr}, 32'd0);
    save_req = 1'b0;
    step();

    // enable low ignores load/save
    enable = 1'b0;
    load_req = 1'b1;
    save_req = 1'b1;
    repeat (3) step();
    check_eq("dis_idle", {29'd0, busy, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
    load_req = 1'b0;
    save_req = 1'b0;
    enable = 1'b1;
    step();

    // ACK timeout, then a good load clears err
    slot = 2'd0;
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    n = 0;
    while (sd_if.sd_rd && n < 1000) begin
      step();
      n++;
    end
    check_eq("to_len", 32'(n), 32'd255);
    check_eq("to_err", 32'(err), 32'd1);
    check_eq("to_idle", {30'd0, busy, sd_if.sd_rd}, 32'd0);
    for (int i = 0; i < 16; i++) lba_exp_q.push_back(32'(i));
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    hps_serve(1'b1, 16, 10, -1);
    check_eq("to_err_clr", 32'(err), 32'd0);

    // reset during sector 5 of a load, request held high through reset
    slot = 2'd1;
    for (int i = 0; i < 5; i++) lba_exp_q.push_back(32'h10 + 32'(i));
    load_req = 1'b1;
    step();
    hps_serve(1'b1, 5, 4, -1);
    n = 0;
    while (!sd_if.sd_rd && n < 50) begin
      step();
      n++;
    end
    check_eq("rst_sec5_lba", sd_if.sd_lba, 32'h15);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst", {30'd0, busy, sd_if.sd_rd}, 32'd0);
    repeat (2) @(posedge clk_sys);
    #3 reset_n = 1'b1;
    repeat (10) step();
    check_eq("no_restart", {29'd0, busy, sd_if.sd_rd, sd_if.sd_wr}, 32'd0);
    check_eq("no_restart_state", 32'(dbg_state), 32'd0);
    load_req = 1'b0;
    step();
    check_eq("final_exp_empty", 32'(exp_q.size() + lba_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end
endmodule
